// File: rtl/fsk_tx_scheduler_if.sv
// Byte-stream handshake between a payload source and the FSK symbol scheduler.
// The source drives data/valid/last and the scheduler answers with ready.
interface fsk_tx_scheduler_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_last;
  logic       in_ready;

  modport master (
    output in_data,
    output in_valid,
    output in_last,
    input  in_ready
  );

  modport slave (
    input  in_data,
    input  in_valid,
    input  in_last,
    output in_ready
  );
endinterface

// File: rtl/fsk_tx_scheduler.sv
// Slices a byte stream into M-ary FSK symbols and paces them to the modulator.
// Define FSK_SCHED_GUARD_EN to append GUARD_SYMBOLS zero symbols to every frame.
module fsk_tx_scheduler #(
  parameter int SAMPLES_PER_SYMBOL = 16,
  parameter int SYNC_WAIT          = 12
`ifdef FSK_SCHED_GUARD_EN
  ,
  parameter int GUARD_SYMBOLS      = 2
`endif
) (
  input  logic              clk,
  input  logic              reset,
  fsk_tx_scheduler_if.slave in_bus,
  input  logic [1:0]        mode,
  output logic [3:0]        mod_data,
  output logic              mod_start,
  output logic              sym_strobe,
  output logic              busy,
  output logic              frame_done,
  output logic              underrun
);

  localparam int SYM_W  = $clog2(SAMPLES_PER_SYMBOL);
  localparam int SYNC_W = $clog2(SYNC_WAIT + 1);
  localparam logic [SYM_W-1:0]  SYM_LAST  = SYM_W'(SAMPLES_PER_SYMBOL - 1);
  localparam logic [SYNC_W-1:0] SYNC_LAST = SYNC_W'(SYNC_WAIT - 1);
`ifdef FSK_SCHED_GUARD_EN
  localparam int GUARD_W = $clog2(GUARD_SYMBOLS + 1);
  localparam logic [GUARD_W-1:0] GUARD_LAST = GUARD_W'(GUARD_SYMBOLS - 1);
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_SYNC,
    S_DATA,
    S_GUARD
  } state_t;

  state_t            state, state_next;
  logic [15:0]       bit_buf, bit_buf_next;
  logic [4:0]        buf_cnt, buf_cnt_next;
  logic [2:0]        bps, bps_next;
  logic              last_seen, last_seen_next;
  logic [SYNC_W-1:0] sync_cnt, sync_cnt_next;
  logic [SYM_W-1:0]  sym_cnt, sym_cnt_next;
`ifdef FSK_SCHED_GUARD_EN
  logic [GUARD_W-1:0] guard_cnt, guard_cnt_next;
`endif

  logic [3:0] mod_data_r, mod_data_next;
  logic       mod_start_r, mod_start_next;
  logic       sym_strobe_r, sym_strobe_next;
  logic       frame_done_r, frame_done_next;
  logic       underrun_r, underrun_next;

  logic        in_ready_c;
  logic        accept;
  logic        boundary;
  logic        do_emit;
  logic [4:0]  pop_n;
  logic [15:0] popped_buf;
  logic [4:0]  popped_cnt;
  logic [15:0] push_bits;
  logic [3:0]  sym_mask;
  logic [3:0]  emit_sym;

  // Space for another byte only while the buffer can take 8 more bits after any pop.
  always_comb begin
    in_ready_c = (state == S_IDLE) ||
                 (((state == S_SYNC) || (state == S_DATA)) && !last_seen && (buf_cnt <= 5'd8));
    accept     = in_bus.in_valid && in_ready_c;
  end

  assign in_bus.in_ready = in_ready_c;

  // Boundary decision and buffer datapath; the buffer is MSB-aligned and bits below
  // buf_cnt are always zero, so a short final symbol comes out zero-padded for free.
  always_comb begin
    boundary = ((state == S_SYNC) && (sync_cnt == SYNC_LAST)) ||
               ((state == S_DATA) && (sym_cnt == SYM_LAST));
    pop_n    = '0;
    do_emit  = 1'b0;
    if (boundary) begin
      if (buf_cnt >= {2'b00, bps}) begin
        pop_n   = {2'b00, bps};
        do_emit = 1'b1;
      end else if (last_seen && (buf_cnt != 5'd0)) begin
        pop_n   = buf_cnt;
        do_emit = 1'b1;
      end
    end
    popped_buf = bit_buf << pop_n;
    popped_cnt = buf_cnt - pop_n;
    push_bits  = {in_bus.in_data, 8'h00} >> popped_cnt;
    case (bps)
      3'd4:    sym_mask = 4'hF;
      3'd3:    sym_mask = 4'hE;
      3'd2:    sym_mask = 4'hC;
      default: sym_mask = 4'h8;
    endcase
    emit_sym = bit_buf[15:12] & sym_mask;
  end

  always_comb begin
    state_next      = state;
    bit_buf_next    = bit_buf;
    buf_cnt_next    = buf_cnt;
    bps_next        = bps;
    last_seen_next  = last_seen;
    sync_cnt_next   = sync_cnt;
    sym_cnt_next    = sym_cnt;
`ifdef FSK_SCHED_GUARD_EN
    guard_cnt_next  = guard_cnt;
`endif
    mod_data_next   = mod_data_r;
    mod_start_next  = 1'b0;
    sym_strobe_next = 1'b0;
    frame_done_next = 1'b0;
    underrun_next   = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (accept) begin
          bps_next       = 3'd4 - {1'b0, mode};
          bit_buf_next   = {in_bus.in_data, 8'h00};
          buf_cnt_next   = 5'd8;
          last_seen_next = in_bus.in_last;
          sync_cnt_next  = '0;
          sym_cnt_next   = '0;
          mod_start_next = 1'b1;
          state_next     = S_SYNC;
        end
      end

      S_SYNC, S_DATA: begin
        if (state == S_SYNC) begin
          sync_cnt_next = sync_cnt + SYNC_W'(1);
        end else begin
          sym_cnt_next = sym_cnt + SYM_W'(1);
        end
        if (accept) begin
          bit_buf_next   = popped_buf | push_bits;
          buf_cnt_next   = popped_cnt + 5'd8;
          last_seen_next = in_bus.in_last;
        end else begin
          bit_buf_next = popped_buf;
          buf_cnt_next = popped_cnt;
        end
        if (boundary) begin
          sym_cnt_next = '0;
          if (do_emit) begin
            state_next      = S_DATA;
            mod_data_next   = emit_sym;
            sym_strobe_next = 1'b1;
          end else if (last_seen) begin
            mod_data_next = 4'h0;
`ifdef FSK_SCHED_GUARD_EN
            state_next      = S_GUARD;
            sym_strobe_next = 1'b1;
            guard_cnt_next  = '0;
`else
            state_next      = S_IDLE;
            frame_done_next = 1'b1;
            last_seen_next  = 1'b0;
`endif
          end else begin
            // Starved mid-frame: abort and drop whatever arrives on this edge.
            state_next     = S_IDLE;
            underrun_next  = 1'b1;
            mod_data_next  = 4'h0;
            bit_buf_next   = '0;
            buf_cnt_next   = '0;
            last_seen_next = 1'b0;
          end
        end
      end

`ifdef FSK_SCHED_GUARD_EN
      S_GUARD: begin
        sym_cnt_next = sym_cnt + SYM_W'(1);
        if (sym_cnt == SYM_LAST) begin
          sym_cnt_next = '0;
          if (guard_cnt == GUARD_LAST) begin
            state_next      = S_IDLE;
            frame_done_next = 1'b1;
            last_seen_next  = 1'b0;
          end else begin
            guard_cnt_next  = guard_cnt + GUARD_W'(1);
            sym_strobe_next = 1'b1;
          end
        end
      end
`endif

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      bit_buf      <= '0;
      buf_cnt      <= '0;
      bps          <= 3'd4;
      last_seen    <= 1'b0;
      sync_cnt     <= '0;
      sym_cnt      <= '0;
`ifdef FSK_SCHED_GUARD_EN
      guard_cnt    <= '0;
`endif
      mod_data_r   <= '0;
      mod_start_r  <= 1'b0;
      sym_strobe_r <= 1'b0;
      frame_done_r <= 1'b0;
      underrun_r   <= 1'b0;
    end else begin
      state        <= state_next;
      bit_buf      <= bit_buf_next;
      buf_cnt      <= buf_cnt_next;
      bps          <= bps_next;
      last_seen    <= last_seen_next;
      sync_cnt     <= sync_cnt_next;
      sym_cnt      <= sym_cnt_next;
`ifdef FSK_SCHED_GUARD_EN
      guard_cnt    <= guard_cnt_next;
`endif
      mod_data_r   <= mod_data_next;
      mod_start_r  <= mod_start_next;
      sym_strobe_r <= sym_strobe_next;
      frame_done_r <= frame_done_next;
      underrun_r   <= underrun_next;
    end
  end

  assign mod_data   = mod_data_r;
  assign mod_start  = mod_start_r;
  assign sym_strobe = sym_strobe_r;
  assign frame_done = frame_done_r;
  assign underrun   = underrun_r;
  assign busy       = (state != S_IDLE);

endmodule

// File: doc/fsk_tx_scheduler.md
Name: fsk_tx_scheduler

Overview:
- Transmit-side symbol scheduler that feeds the FSK modulator.
- Accepts a byte stream with valid/ready/last handshake.
- Slices bytes into M-ary symbols (16/8/4/2-FSK, selectable per frame) and drives the modulator's 4-bit symbol input and start/sync pulse.
- Holds each symbol for a programmable number of clocks; signals frame completion and underrun.

Parameters:
- SAMPLES_PER_SYMBOL, 16: clocks each symbol is held on mod_data (>=2).
- SYNC_WAIT, 12: clocks spent in SYNC after mod_start before the first symbol; covers the modulator's 10-sample sync plus margin.
- GUARD_SYMBOLS, 2: trailing zero symbols appended per frame (FSK_SCHED_GUARD_EN builds only).

Ports:
- clk  input  1  clock
- reset  input  1  reset, asynchronous, active-high
- in_data  input  8  payload byte, MSB transmitted first
- in_valid  input  1  in_data valid
- in_last  input  1  byte is last of frame; qualified by in_valid
- in_ready  output  1  scheduler accepts byte this cycle
- mode  input  2  0=16-FSK (4 b/sym), 1=8-FSK (3), 2=4-FSK (2), 3=2-FSK (1); sampled at frame start
- mod_data  output  4  symbol to modulator data_in
- mod_start  output  1  one-cycle pulse, modulator start
- sym_strobe  output  1  one-cycle pulse on every cycle mod_data takes a new symbol
- busy  output  1  high in any state other than IDLE
- frame_done  output  1  one-cycle pulse, frame finished normally
- underrun  output  1  one-cycle pulse, frame aborted for lack of data

Behaviour:
- Reset (async): state=IDLE; bit buffer cleared, buf_cnt=0; counters 0; last_seen=0.
- Reset values of outputs: mod_data=0, mod_start=0, sym_strobe=0, frame_done=0, underrun=0, busy=0. in_ready=1 after reset, since it is combinational from state.
- Internal buffer: 16-bit MSB-aligned shift register with buf_cnt 0..16. bps is latched from mode.
- Accept condition: in_valid && in_ready.
- in_ready = (state==IDLE) || (state in {SYNC, DATA} && !last_seen && buf_cnt<=8).
- Accepted byte is appended below the existing buf_cnt bits; in_last sets last_seen.
- IDLE:
  - On accept: latch bps from mode, load byte, go to SYNC.
  - mod_start=1 on the next cycle, the first SYNC cycle; sync counter starts at 0.
- SYNC:
  - Counter increments each cycle; bytes may be accepted.
  - When count==SYNC_WAIT-1, go to DATA and perform a symbol boundary in that same cycle.
- Symbol boundary (DATA entry, then every SAMPLES_PER_SYMBOL cycles):
  - buf_cnt>=bps: pop top bps bits into s; mod_data = s << (4-bps) (maximum tone spacing); sym_strobe=1.
  - else if last_seen and buf_cnt>0: pop remaining bits, zero-padded at the LSBs to bps, then same mapping.
  - else if last_seen and buf_cnt==0: frame end. Go to GUARD if enabled, otherwise IDLE with frame_done=1 and mod_data=0.
  - else (no data, not last): underrun=1, mod_data=0, go to IDLE; buffer cleared.
- Push and pop in the same cycle are legal: buf_cnt_next = buf_cnt - popped + 8.
- Symbol counter runs 0..SAMPLES_PER_SYMBOL-1 and wraps; mod_data is stable between boundaries.
- mode changes mid-frame are ignored until the next IDLE accept.
- Back-to-back frames: IDLE re-accepts on the cycle after frame_done; a new sync is issued for every frame.
- Reset mid-frame: immediate IDLE; no frame_done or underrun pulse.

Optional Feature:
- FSK_SCHED_GUARD_EN defined:
  - Frame end enters GUARD; mod_data=0 for GUARD_SYMBOLS symbol periods, with sym_strobe at each.
  - Then IDLE with frame_done=1.
  - in_ready=0 in GUARD.
- Undefined: no GUARD state; frame_done is asserted at the end-detect boundary.

Test Plan:
- SPS=4, SYNC_WAIT=12, mode=0, one byte 0xA5 with last:
  - mod_start 1 cycle after accept.
  - mod_data=0xA for 4 clocks starting 12 clocks later, then 0x5 for 4 clocks.
  - frame_done at the next boundary, busy falls.
- mode=3, byte 0x80 with last: mod_data sequence 8,0,0,0,0,0,0,0 (one per symbol period), 8 sym_strobes, then frame_done.
- mode=1, byte 0xFF with last: mod_data 14,14,12 (the third symbol is padded 110), then frame_done.
- mode=0, two bytes then in_valid held low with no last: symbols A,5,3,C for 0xA5,0x3C; next boundary gives underrun=1, mod_data=0, IDLE.
- Backpressure, mode=3 with continuous valid: in_ready drops whenever buf_cnt>8; no byte is lost or duplicated; 16 bits are emitted in order.
- Reset asserted mid-DATA: all outputs 0 asynchronously. After release, a new byte restarts with mod_start. With FSK_SCHED_GUARD_EN, two extra 0 symbols precede frame_done.
